// File: rtl/led_test_pkg.sv
// Shared types and helpers for the running-light LED driver.
// Provides the counter-width helper, the LED reset pattern and the direction enum.
package led_test_pkg;

    // Direction of travel for the ping-pong variant.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Only bit 0 lit; callers cast this down to their own LED width.
    localparam logic [63:0] LED_RESET_PATTERN = 64'd1;

    // max(1, $clog2(n)), so a one-cycle prescaler still gets a real register.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_test_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_CYCLES clocks.
// Ports: clk, rst_n (sync, active-low), tick (combinational, high when cnt == TICK_CYCLES-1).
module tick_gen
    import led_test_pkg::*;
#(
    parameter int TICK_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = cnt_width(TICK_CYCLES);

    logic [CNT_W-1:0] cnt;

    // With TICK_CYCLES == 1 the counter sits at 0 and tick is always high.
    assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_test.sv
// Running-light LED driver: advances a one-hot pattern on led once per step.
// Ports: clk, rst_n (sync, active-low), led[LED_WIDTH-1:0] (registered, active-high).
// Optional: define LED_PINGPONG_EN to bounce the light between the ends instead of rotating.
module led_test
    import led_test_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int STEP_HZ     = 1,
    parameter int LED_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [LED_WIDTH-1:0] led
);

    localparam int TICK_CYCLES = CLK_FREQ_HZ / STEP_HZ;
    localparam logic [LED_WIDTH-1:0] LED_RST = LED_WIDTH'(LED_RESET_PATTERN);

    if (TICK_CYCLES < 1) begin : g_bad_tick
        $fatal(1, "led_test: TICK_CYCLES must be >= 1");
    end
    if (LED_WIDTH < 2) begin : g_bad_width
        $fatal(1, "led_test: LED_WIDTH must be >= 2");
    end

    logic                 tick;
    logic [LED_WIDTH-1:0] led_nxt;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

`ifdef LED_PINGPONG_EN
    dir_t dir;
    dir_t dir_nxt;

    // Turn around as the shift leaves an end, so each end is lit for one step.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        if (tick) begin
            unique case (dir)
                DIR_LEFT: begin
                    if (led[LED_WIDTH-1]) begin
                        dir_nxt = DIR_RIGHT;
                        led_nxt = led >> 1;
                    end else begin
                        led_nxt = led << 1;
                    end
                end
                DIR_RIGHT: begin
                    if (led[0]) begin
                        dir_nxt = DIR_LEFT;
                        led_nxt = led << 1;
                    end else begin
                        led_nxt = led >> 1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir <= DIR_LEFT;
        end else begin
            dir <= dir_nxt;
        end
    end
`else
    always_comb begin
        led_nxt = led;
        if (tick) begin
            led_nxt = {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led <= LED_RST;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_test.sv
// Directed bench for led_test: reset, latency, step sequence, mid-step reset, TICK_CYCLES=1.
// Build with LED_PINGPONG_EN defined to exercise the bouncing sequence.
module tb_led_test;

    logic       clk;
    logic       rst_n;
    logic [3:0] led;
    logic [3:0] led_fast;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LED_PINGPONG_EN
    localparam int PLEN = 6;
    localparam int RUN_TICKS = 8;
    logic [3:0] seq [PLEN] = '{4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001};
`else
    localparam int PLEN = 4;
    localparam int RUN_TICKS = 32;
    logic [3:0] seq [PLEN] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    led_test #(
        .CLK_FREQ_HZ(8),
        .STEP_HZ    (1),
        .LED_WIDTH  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .led  (led)
    );

    led_test #(
        .CLK_FREQ_HZ(1),
        .STEP_HZ    (1),
        .LED_WIDTH  (4)
    ) dut_fast (
        .clk  (clk),
        .rst_n(rst_n),
        .led  (led_fast)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (led !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_led edge %0d: got %b want 0001", i, led);
            end
        end
        n_checks++;
        if (dut.u_tick.cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", dut.u_tick.cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_release();
        for (int i = 1; i <= 7; i++) begin
            step();
            n_checks++;
            if (led !== 4'b0001) begin
                n_fail++;
                $display("FAIL release_hold edge %0d: got %b want 0001", i, led);
            end
        end
        step();
        n_checks++;
        if (led !== 4'b0010) begin
            n_fail++;
            $display("FAIL release_first: got %b want 0010", led);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] prev;
        prev = 4'b0010;
        for (int t = 1; t <= RUN_TICKS; t++) begin
            for (int c = 1; c <= 7; c++) begin
                step();
                n_checks++;
                if (led !== prev || !$onehot(led)) begin
                    n_fail++;
                    $display("FAIL seq_hold tick %0d cyc %0d: got %b want %b",
                             t, c, led, prev);
                end
            end
            step();
            n_checks++;
            if (led !== seq[t % PLEN]) begin
                n_fail++;
                $display("FAIL seq_step tick %0d: got %b want %b",
                         t, led, seq[t % PLEN]);
            end
            prev = seq[t % PLEN];
        end
    endtask

    task automatic test_mid_reset();
        int waited;
        waited = 0;
        while (led !== 4'b0100 && waited < 100) begin
            step();
            waited++;
        end
        n_checks++;
        if (led !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_wait: got %b want 0100 within 100 cycles", led);
        end
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        n_checks++;
        if (led !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0001", led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_checks++;
            if (led !== 4'b0001) begin
                n_fail++;
                $display("FAIL mid_hold edge %0d: got %b want 0001", i, led);
            end
        end
        step();
        n_checks++;
        if (led !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_first: got %b want 0010", led);
        end
    endtask

    task automatic test_fast();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        n_checks++;
        if (led_fast !== 4'b0001) begin
            n_fail++;
            $display("FAIL fast_reset: got %b want 0001", led_fast);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (led_fast !== seq[k % PLEN]) begin
                n_fail++;
                $display("FAIL fast_step %0d: got %b want %b",
                         k, led_fast, seq[k % PLEN]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_release();
        test_sequence();
        test_mid_reset();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_test.md
Name: led_test

Overview:
- Running-light LED driver for board bring-up.
- Divides the system clock down to a slow step rate and advances a one-hot pattern on `led[3:0]` once per step.
- Top-level leaf block, driven directly by the board oscillator (50 MHz nominal, 20 ns period) and the board reset button.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency in Hz.
- STEP_HZ, 1, pattern advance rate in Hz.
- LED_WIDTH, 4, number of LED outputs; must be >= 2.
- Derived localparam TICK_CYCLES = CLK_FREQ_HZ / STEP_HZ; must be >= 1 (elaboration-time check, fatal if violated).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- led  output  LED_WIDTH  LED drive, active-high (1 = LED on), registered.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low: sampled only on the `clk` rising edge; no asynchronous path.
- Prescaler:
  - Counter `cnt`, width max(1, $clog2(TICK_CYCLES)), counts 0..TICK_CYCLES-1.
  - `tick` = (cnt == TICK_CYCLES-1), combinational.
  - On tick, `cnt` wraps to 0; otherwise it increments.
  - TICK_CYCLES == 1: tick is asserted every cycle.
- Pattern register `led`:
  - Reset value: LED_WIDTH'b0…01 (only bit 0 set).
  - On each tick, rotate left by one: 0001 -> 0010 -> 0100 -> 1000 -> 0001 (wraps).
  - Holds its value between ticks.
- Reset values: cnt = 0, led = 0001, dir = left (when the optional feature is present).
- Latency: the first `led` change occurs on the TICK_CYCLES-th rising edge after the first edge with rst_n = 1. Each later change follows exactly TICK_CYCLES cycles after the previous one.
- Reset mid-operation: asserting rst_n low for any edge returns cnt, led and dir to reset values on that edge. Prescaler phase restarts from 0.
- Invariant: `led` is always exactly one-hot; it is never 0 and never has more than one bit set.
- No other outputs; no handshakes.

Optional Feature:
- Macro: LED_PINGPONG_EN.
- Defined: a 1-bit direction register `dir` (0 = left, 1 = right; reset to left) selects the step.
  - Moving left: shift toward the MSB. When the pattern reaches the MSB, the next tick sets dir to right and shifts right.
  - Moving right: at the LSB, the next tick sets dir to left and shifts left.
  - Sequence for width 4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - The end LED is lit for one step only, never two consecutive steps.
- Undefined: pure left rotation as above. No `dir` register is synthesized.

Decomposition:
- Package `led_test_pkg`:
  - function computing counter width (max(1, $clog2(n))).
  - localparam for the reset pattern.
  - enum `dir_t` {DIR_LEFT, DIR_RIGHT}.
- One sub-module `tick_gen`:
  - Parameter: TICK_CYCLES.
  - Ports: clk, rst_n, tick.
  - Contains the prescaler.
- Pattern and direction logic stay in `led_test`.

Test Plan (bench uses CLK_FREQ_HZ=8, STEP_HZ=1 -> TICK_CYCLES=8; 20 ns clock; rst_n low for the first 100 ns):
- Reset held -> `led` = 0001 on every edge while rst_n = 0; cnt = 0.
- Release reset -> `led` stays 0001 for 7 edges and becomes 0010 on the 8th edge after release.
- Run 32 ticks without macro -> sequence 0010, 0100, 1000, 0001 repeating. Interval between changes is exactly 8 cycles. One-hot checked every cycle.
- Assert rst_n low for one edge mid-step while led = 0100 -> `led` = 0001 on that edge. Next change comes 8 cycles after release.
- With LED_PINGPONG_EN, run 8 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
- Parameter corner, TICK_CYCLES=1 (CLK_FREQ_HZ=STEP_HZ=1) -> `led` advances on every edge after reset release.
